// File: rtl/fb_fill_engine.sv
// Rectangle-fill engine: turns one fill command into a stream of 32-bit word
// writes with byte strobes covering the clipped rectangle in the framebuffer.
module fb_fill_engine #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE_ADDR = 32'hD000_0000,
  parameter int                    IMG_WIDTH    = 64,
  parameter int                    IMG_HEIGHT   = 64
) (
  input  logic                  ahb_clk,
  input  logic                  n_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [6:0]            cmd_x0,
  input  logic [6:0]            cmd_y0,
  input  logic [6:0]            cmd_w,
  input  logic [6:0]            cmd_h,
  input  logic [7:0]            cmd_color,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [3:0]            wr_strb,
  output logic                  busy,
  output logic                  done
);

  localparam int         WW     = $clog2(IMG_WIDTH) - 2;
  localparam logic [7:0] IMG_W8 = 8'(IMG_WIDTH);
  localparam logic [7:0] IMG_H8 = 8'(IMG_HEIGHT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [WW-1:0]   word_r, word_s, first_word_r, first_word_s, last_word_r, last_word_s;
  logic [7:0]      y_r, y_s, y_last_r, y_last_s;
  logic [1:0]      lane_lo_r, lane_lo_s, lane_hi_r, lane_hi_s;
  logic [7:0]      color_r, color_s;

  logic                  cmd_ready_r, cmd_ready_s;
  logic                  wr_valid_r, wr_valid_s;
  logic [ADDR_WIDTH-1:0] wr_addr_r, wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_r, wr_data_s;
  logic [3:0]            wr_strb_r, wr_strb_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;

  logic       cmd_fire_s, empty_s, row_end_s, frame_end_s;
  logic [7:0] xe_sum_s, ye_sum_s, xe_s, ye_s, xe_m1_s, ye_m1_s;

  function automatic logic [3:0] strb_of(input logic [WW-1:0] word, input logic [WW-1:0] first,
                                         input logic [WW-1:0] last, input logic [1:0] lo,
                                         input logic [1:0] hi);
    logic [3:0] m;
    m = 4'hF;
    if (word == first) m = m & (4'hF << lo);
    else               m = m;
    if (word == last)  m = m & (4'hF >> (2'd3 - hi));
    else               m = m;
    return m;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [7:0] y, input logic [WW-1:0] word);
    return FB_BASE_ADDR + ADDR_WIDTH'(y) * ADDR_WIDTH'(IMG_WIDTH) + ADDR_WIDTH'({word, 2'b00});
  endfunction

  // Command clipping; sums are 8 bits wide so x0+w never wraps.
  always_comb begin
    cmd_fire_s  = cmd_valid && cmd_ready_r;
    xe_sum_s    = {1'b0, cmd_x0} + {1'b0, cmd_w};
    ye_sum_s    = {1'b0, cmd_y0} + {1'b0, cmd_h};
    xe_s        = (xe_sum_s > IMG_W8) ? IMG_W8 : xe_sum_s;
    ye_s        = (ye_sum_s > IMG_H8) ? IMG_H8 : ye_sum_s;
    xe_m1_s     = xe_s - 8'd1;
    ye_m1_s     = ye_s - 8'd1;
    empty_s     = (cmd_w == 7'd0) || (cmd_h == 7'd0) ||
                  ({1'b0, cmd_x0} >= IMG_W8) || ({1'b0, cmd_y0} >= IMG_H8);
    row_end_s   = (word_r == last_word_r);
    frame_end_s = row_end_s && (y_r == y_last_r);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_fire_s) state_s = empty_s ? DONE : WRITE;
        else            state_s = IDLE;
      end
      WRITE: begin
        if (wr_ready && frame_end_s) state_s = DONE;
        else                         state_s = WRITE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Walk position: load on accept, step one word per handshake, wrap rows.
  always_comb begin
    word_s       = word_r;
    first_word_s = first_word_r;
    last_word_s  = last_word_r;
    y_s          = y_r;
    y_last_s     = y_last_r;
    lane_lo_s    = lane_lo_r;
    lane_hi_s    = lane_hi_r;
    color_s      = color_r;
    if ((state_r == IDLE) && cmd_fire_s) begin
      word_s       = WW'(cmd_x0 >> 2);
      first_word_s = WW'(cmd_x0 >> 2);
      last_word_s  = WW'(xe_m1_s >> 2);
      y_s          = {1'b0, cmd_y0};
      y_last_s     = ye_m1_s;
      lane_lo_s    = cmd_x0[1:0];
      lane_hi_s    = xe_m1_s[1:0];
      color_s      = cmd_color;
    end else if ((state_r == WRITE) && wr_ready) begin
      if (row_end_s) begin
        word_s = first_word_r;
        y_s    = y_r + 8'd1;
      end else begin
        word_s = word_r + WW'(1);
      end
    end else begin
      word_s = word_r;
    end
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    cmd_ready_s = (state_s == IDLE);
    busy_s      = (state_s != IDLE);
    done_s      = (state_s == DONE);
    if (state_s == WRITE) begin
      wr_valid_s = 1'b1;
      wr_addr_s  = addr_of(y_s, word_s);
      wr_data_s  = DATA_WIDTH'({4{color_s}});
      wr_strb_s  = strb_of(word_s, first_word_s, last_word_s, lane_lo_s, lane_hi_s);
    end else begin
      wr_valid_s = 1'b0;
      wr_addr_s  = '0;
      wr_data_s  = '0;
      wr_strb_s  = 4'h0;
    end
  end

  // State register.
  always_ff @(posedge ahb_clk or negedge n_rst) begin
    if (!n_rst) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Walk position registers.
  always_ff @(posedge ahb_clk or negedge n_rst) begin
    if (!n_rst) begin
      word_r       <= '0;
      first_word_r <= '0;
      last_word_r  <= '0;
      y_r          <= 8'd0;
      y_last_r     <= 8'd0;
      lane_lo_r    <= 2'd0;
      lane_hi_r    <= 2'd0;
      color_r      <= 8'd0;
    end else begin
      word_r       <= word_s;
      first_word_r <= first_word_s;
      last_word_r  <= last_word_s;
      y_r          <= y_s;
      y_last_r     <= y_last_s;
      lane_lo_r    <= lane_lo_s;
      lane_hi_r    <= lane_hi_s;
      color_r      <= color_s;
    end
  end

  // Output registers.
  always_ff @(posedge ahb_clk or negedge n_rst) begin
    if (!n_rst) begin
      cmd_ready_r <= 1'b0;
      wr_valid_r  <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      wr_strb_r   <= 4'h0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cmd_ready_r <= cmd_ready_s;
      wr_valid_r  <= wr_valid_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      wr_strb_r   <= wr_strb_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign wr_valid  = wr_valid_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign wr_strb   = wr_strb_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_fb_fill_engine.sv
// Directed bench for fb_fill_engine: table of fill commands with hand-computed
// write summaries, plus backpressure and mid-command reset sequences.
module tb_fb_fill_engine;

  logic        ahb_clk, n_rst;
  logic        cmd_valid, cmd_ready;
  logic [6:0]  cmd_x0, cmd_y0, cmd_w, cmd_h;
  logic [7:0]  cmd_color;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        busy, done;

  fb_fill_engine dut (
    .ahb_clk(ahb_clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .busy(busy), .done(done)
  );

  initial ahb_clk = 1'b0;
  always #5 ahb_clk = ~ahb_clk;

  typedef struct {
    logic [6:0]  x0, y0, w, h;
    logic [7:0]  color;
    int          n;
    logic [31:0] a_first;
    logic [3:0]  s_first;
    logic [31:0] a_last;
    logic [3:0]  s_last;
    int          pix;
    int          lat;
  } vec_t;

  vec_t        tbl [9];
  int          checks = 0;
  int          errors = 0;
  logic [35:0] wq [$];
  logic [35:0] ref_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one command and follow it to done; bp randomises wr_ready and
  // throws ignored cmd_valid pulses at the busy engine.
  task automatic run_cmd(input vec_t v, input bit bp, input bit seq);
    int n, pix, lat;
    bit got_done, prev_v, prev_r;
    logic [31:0] fa, la, pa, pd;
    logic [3:0]  fs, ls, ps;
    n = 0; pix = 0; lat = 0; got_done = 0; prev_v = 0; prev_r = 0;
    fa = '0; la = '0; fs = '0; ls = '0; pa = '0; pd = '0; ps = '0;
    wq.delete();
    @(negedge ahb_clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_x0 = v.x0; cmd_y0 = v.y0; cmd_w = v.w; cmd_h = v.h; cmd_color = v.color;
    cmd_valid = 1'b1; wr_ready = 1'b0;
    for (int c = 1; c <= 2000 && !got_done; c++) begin
      @(negedge ahb_clk);
      if (prev_v && !prev_r) begin
        chk("stall_valid", {31'd0, wr_valid}, 32'd1);
        chk("stall_addr", wr_addr, pa);
        chk("stall_data", wr_data, pd);
        chk("stall_strb", {28'd0, wr_strb}, {28'd0, ps});
      end
      if (c == 1) begin
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("ready_low_after_accept", {31'd0, cmd_ready}, 32'd0);
      end
      if (done) begin
        got_done = 1; lat = c;
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        chk("no_write_in_done", {31'd0, wr_valid}, 32'd0);
      end
      if (bp && !done) begin
        cmd_valid = ($urandom_range(0, 1) == 1);
        cmd_x0 = 7'($urandom_range(0, 63)); cmd_y0 = 7'($urandom_range(0, 63));
        cmd_w = 7'($urandom_range(1, 8)); cmd_h = 7'($urandom_range(1, 8));
        wr_ready = ($urandom_range(0, 2) != 0);
      end else begin
        cmd_valid = 1'b0;
        wr_ready = 1'b1;
      end
      if (wr_valid && wr_ready) begin
        n++;
        if (n == 1) begin fa = wr_addr; fs = wr_strb; end
        la = wr_addr; ls = wr_strb;
        pix += $countones(wr_strb);
        chk("wr_data", wr_data, {4{v.color}});
        if (seq) chk("seq_addr", wr_addr, 32'hD000_0000 + 32'(4 * (n - 1)));
        wq.push_back({wr_strb, wr_addr});
      end
      prev_v = wr_valid; prev_r = wr_ready; pa = wr_addr; pd = wr_data; ps = wr_strb;
    end
    cmd_valid = 1'b0; wr_ready = 1'b0;
    if (!got_done) chk("done_timeout", 32'd0, 32'd1);
    chk("n_writes", n, v.n);
    chk("pixels", pix, v.pix);
    if (v.n > 0) begin
      chk("first_addr", fa, v.a_first);
      chk("first_strb", {28'd0, fs}, {28'd0, v.s_first});
      chk("last_addr", la, v.a_last);
      chk("last_strb", {28'd0, ls}, {28'd0, v.s_last});
    end
    if (!bp) chk("done_latency", lat, v.lat);
    @(negedge ahb_clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_no_write", {31'd0, wr_valid}, 32'd0);
    chk("single_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cnt;
    //         x0     y0     w      h      color   n     first          fs     last           ls     pix   lat
    tbl[0] = '{7'd0,  7'd0,  7'd64, 7'd64, 8'h00,  1024, 32'hD000_0000, 4'hF, 32'hD000_0FFC, 4'hF, 4096, 1025};
    tbl[1] = '{7'd5,  7'd2,  7'd6,  7'd1,  8'hAB,  2,    32'hD000_0084, 4'hE, 32'hD000_0088, 4'h7, 6,    3};
    tbl[2] = '{7'd63, 7'd63, 7'd1,  7'd1,  8'h5A,  1,    32'hD000_0FFC, 4'h8, 32'hD000_0FFC, 4'h8, 1,    2};
    tbl[3] = '{7'd60, 7'd10, 7'd20, 7'd2,  8'h33,  2,    32'hD000_02BC, 4'hF, 32'hD000_02FC, 4'hF, 8,    3};
    tbl[4] = '{7'd3,  7'd3,  7'd0,  7'd5,  8'h44,  0,    32'h0,         4'h0, 32'h0,         4'h0, 0,    1};
    tbl[5] = '{7'd64, 7'd0,  7'd4,  7'd4,  8'h55,  0,    32'h0,         4'h0, 32'h0,         4'h0, 0,    1};
    tbl[6] = '{7'd1,  7'd0,  7'd10, 7'd2,  8'h11,  6,    32'hD000_0000, 4'hE, 32'hD000_0048, 4'h7, 20,   7};
    tbl[7] = '{7'd0,  7'd62, 7'd4,  7'd10, 8'h77,  2,    32'hD000_0F80, 4'hF, 32'hD000_0FC0, 4'hF, 8,    3};
    tbl[8] = '{7'd2,  7'd1,  7'd3,  7'd3,  8'hC3,  6,    32'hD000_0040, 4'hC, 32'hD000_00C4, 4'h1, 9,    7};

    n_rst = 1'b0; cmd_valid = 1'b0; wr_ready = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    #3;
    chk("rst_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_addr", wr_addr, 32'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_strb", {28'd0, wr_strb}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge ahb_clk);
    n_rst = 1'b1;
    @(negedge ahb_clk);
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 9; i++) run_cmd(tbl[i], 1'b0, i == 0);

    // Backpressure: same write sequence as the unstalled 3x3 run.
    ref_q = wq;
    run_cmd(tbl[8], 1'b1, 1'b0);
    chk("bp_seq_len", wq.size(), ref_q.size());
    for (int i = 0; i < wq.size() && i < ref_q.size(); i++)
      chk("bp_seq_word", wq[i][31:0], ref_q[i][31:0]);

    // Reset ten writes into a full clear.
    @(negedge ahb_clk);
    cmd_x0 = 7'd0; cmd_y0 = 7'd0; cmd_w = 7'd64; cmd_h = 7'd64; cmd_color = 8'hFF;
    cmd_valid = 1'b1; wr_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 50 && cnt < 10; c++) begin
      @(negedge ahb_clk);
      cmd_valid = 1'b0;
      if (wr_valid) cnt++;
    end
    chk("pre_reset_writes", cnt, 32'd10);
    @(posedge ahb_clk);
    #2 n_rst = 1'b0;
    #1;
    chk("abort_valid", {31'd0, wr_valid}, 32'd0);
    chk("abort_addr", wr_addr, 32'd0);
    chk("abort_data", wr_data, 32'd0);
    chk("abort_strb", {28'd0, wr_strb}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (2) @(negedge ahb_clk);
    n_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge ahb_clk);
      chk("post_reset_no_write", {31'd0, wr_valid}, 32'd0);
      chk("post_reset_no_done", {31'd0, done}, 32'd0);
    end
    wr_ready = 1'b0;
    run_cmd(tbl[1], 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
